id_regfile_scoreboard: RTL and testbench
========================================

// Module: id_regfile_scoreboard
// PURPOSE
//   Decode-stage register file for the pipelined RV32I core: sink end of the WB->ID write-back
//   interface (WB_ID_WD3 / WB_ID_RD_A3 / WB_ID_WE3). Holds x0..x31, serves two read ports with
//   same-cycle write-through bypass, and keeps a per-register pending-write scoreboard that
//   raises a decode stall while an operand's producer is still in flight.
// PARAMETERS
//   XLEN     32  data width of each architectural register
//   NREG     32  number of registers (address width = log2(NREG) = 5)
//   CNT_W    3   width of each pending-write counter (max 2^CNT_W-1 writers in flight per reg)
// PORTS
//   clk          in   1     clock, rising-edge
//   rst          in   1     asynchronous, active-high reset
//   WB_ID_WE3    in   1     write-back enable from write-back stage
//   WB_ID_RD_A3  in   5     write-back destination register
//   WB_ID_WD3    in   XLEN  write-back data
//   id_rs1       in   5     source register 1 of the instruction in decode
//   id_rs2       in   5     source register 2 of the instruction in decode
//   id_rs1_used  in   1     instruction reads rs1
//   id_rs2_used  in   1     instruction reads rs2
//   id_issue     in   1     decode wants to advance its instruction to EX this cycle
//   id_rd        in   5     destination of the decoding instruction
//   id_regwrite  in   1     decoding instruction writes id_rd
//   kill_valid   in   1     an already-issued writer is squashed (branch flush of ID/EX)
//   kill_rd      in   5     destination of the squashed writer
//   id_rd1       out  XLEN  read data port 1 (combinational)
//   id_rd2       out  XLEN  read data port 2 (combinational)
//   id_stall     out  1     operand hazard: hold IF/ID, insert bubble into ID/EX
//   id_accept    out  1     issue accepted this cycle (id_issue & ~id_stall & ~sb_full)
//   sb_full      out  1     counter of id_rd saturated; issue blocked
//   err_underflow out 1     sticky: retire/kill hit a register whose counter was 0
// BEHAVIOUR
//   Reset: all registers 0, all counters 0, err_underflow 0; outputs follow combinationally
//     (id_rd1/id_rd2 = 0, id_stall = 0, sb_full = 0, id_accept = id_issue).
//   x0: reads always return 0; writes, issues, kills with address 0 ignored (no counter change).
//   Write: on posedge clk, if WB_ID_WE3 & RD_A3!=0, reg[RD_A3] <= WD3. Write-back retire
//     decrements cnt[RD_A3] in the same edge.
//   Read bypass: if WB_ID_WE3 & RD_A3==rsN & rsN!=0, id_rdN = WB_ID_WD3, else reg[rsN].
//     Zero-latency: write in cycle t is visible on reads in cycle t.
//   Hazard: eff_cnt(r) = cnt[r] - (retire hit on r ? 1 : 0);
//     id_stall = (rs1_used & rs1!=0 & eff_cnt(rs1)>0) | (rs2_used & rs2!=0 & eff_cnt(rs2)>0).
//   sb_full = id_regwrite & id_rd!=0 & cnt[id_rd]==2^CNT_W-1 & no retire/kill of id_rd this cycle.
//   Issue: id_accept & id_regwrite & id_rd!=0 increments cnt[id_rd].
//   Counter update per register r, per edge: cnt += inc(r) - ret(r) - kill(r); any combination
//     of the three may hit the same r in one cycle and is applied net (e.g. inc+ret -> unchanged).
//   Underflow: a ret/kill that would take cnt below 0 leaves cnt at 0 and sets err_underflow;
//     only rst clears err_underflow.
//   Kill with cnt already decremented by retire in the same cycle follows the net rule above.
//   Reset mid-operation clears counters regardless of in-flight writers; pipeline is reset too.
// TESTING
//   1. rst; read rs1=5,rs2=0 -> id_rd1=0, id_rd2=0, id_stall=0.
//   2. WE3=1,RD_A3=5,WD3=0xDEADBEEF, rs1=5 same cycle -> id_rd1=0xDEADBEEF (bypass); next cycle from array.
//   3. Issue rd=7 (accept=1); next cycle rs1=7 used -> id_stall=1 until WB writes x7; stall=0 in
//      the write cycle, id_rd1 = written value.
//   4. Issue rd=7 and WB retire x7 same cycle with cnt=1 -> cnt stays 1; one later retire -> 0.
//   5. Issue rd=3 seven times (CNT_W=3) -> sb_full=1, id_accept=0 on 8th; kill_rd=3 -> sb_full=0.
//   6. WE3 to x0 with WD3=0xFFFFFFFF -> x0 reads 0; retire x9 at cnt=0 -> err_underflow=1 until rst.

Source files
------------

// File: rtl/id_regfile_scoreboard.sv
// Decode-stage register file with write-through bypass and a per-register
// pending-write scoreboard that stalls decode on in-flight producers.
module id_regfile_scoreboard #(
  parameter int XLEN  = 32,
  parameter int NREG  = 32,
  parameter int CNT_W = 3
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            WB_ID_WE3,
  input  logic [4:0]      WB_ID_RD_A3,
  input  logic [XLEN-1:0] WB_ID_WD3,
  input  logic [4:0]      id_rs1,
  input  logic [4:0]      id_rs2,
  input  logic            id_rs1_used,
  input  logic            id_rs2_used,
  input  logic            id_issue,
  input  logic [4:0]      id_rd,
  input  logic            id_regwrite,
  input  logic            kill_valid,
  input  logic [4:0]      kill_rd,
  output logic [XLEN-1:0] id_rd1,
  output logic [XLEN-1:0] id_rd2,
  output logic            id_stall,
  output logic            id_accept,
  output logic            sb_full,
  output logic            err_underflow
);

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  logic [XLEN-1:0]  regs     [NREG];
  logic [CNT_W-1:0] cnt      [NREG];
  logic [CNT_W-1:0] cnt_next [NREG];

  logic       ret_hit;
  logic       kill_hit;
  logic       inc_hit;
  logic       underflow_hit;
  logic       ret_rs1;
  logic       ret_rs2;
  logic       haz1;
  logic       haz2;
  logic [CNT_W:0] sum_tmp;
  logic [CNT_W:0] dec_tmp;

  assign ret_hit  = WB_ID_WE3 && (WB_ID_RD_A3 != 5'd0);
  assign kill_hit = kill_valid && (kill_rd != 5'd0);
  assign ret_rs1  = ret_hit && (WB_ID_RD_A3 == id_rs1);
  assign ret_rs2  = ret_hit && (WB_ID_RD_A3 == id_rs2);

  // Reads see a same-cycle write-back so a retiring producer never stalls its consumer.
  always_comb begin
    id_rd1 = '0;
    id_rd2 = '0;
    if (id_rs1 != 5'd0) id_rd1 = ret_rs1 ? WB_ID_WD3 : regs[id_rs1];
    if (id_rs2 != 5'd0) id_rd2 = ret_rs2 ? WB_ID_WD3 : regs[id_rs2];
  end

  // A retiring write counts as already complete when judging hazards.
  assign haz1 = id_rs1_used && (id_rs1 != 5'd0) &&
                ({1'b0, cnt[id_rs1]} > {{CNT_W{1'b0}}, ret_rs1});
  assign haz2 = id_rs2_used && (id_rs2 != 5'd0) &&
                ({1'b0, cnt[id_rs2]} > {{CNT_W{1'b0}}, ret_rs2});
  assign id_stall = haz1 || haz2;

  assign sb_full = id_regwrite && (id_rd != 5'd0) && (cnt[id_rd] == CNT_MAX) &&
                   !(ret_hit && (WB_ID_RD_A3 == id_rd)) &&
                   !(kill_hit && (kill_rd == id_rd));

  assign id_accept = id_issue && !id_stall && !sb_full;
  assign inc_hit   = id_accept && id_regwrite && (id_rd != 5'd0);

  // Issue, retire and kill are summed per register; a negative result clamps to zero.
  always_comb begin
    underflow_hit = 1'b0;
    sum_tmp       = '0;
    dec_tmp       = '0;
    for (int r = 0; r < NREG; r++) begin
      cnt_next[r] = cnt[r];
    end
    for (int r = 1; r < NREG; r++) begin
      sum_tmp = {1'b0, cnt[r]} + {{CNT_W{1'b0}}, (inc_hit && (id_rd == 5'(r)))};
      dec_tmp = {{CNT_W{1'b0}}, (ret_hit && (WB_ID_RD_A3 == 5'(r)))} +
                {{CNT_W{1'b0}}, (kill_hit && (kill_rd == 5'(r)))};
      if (sum_tmp >= dec_tmp) begin
        cnt_next[r] = CNT_W'(sum_tmp - dec_tmp);
      end else begin
        cnt_next[r]   = '0;
        underflow_hit = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int r = 0; r < NREG; r++) begin
        regs[r] <= '0;
        cnt[r]  <= '0;
      end
      err_underflow <= 1'b0;
    end else begin
      if (ret_hit) regs[WB_ID_RD_A3] <= WB_ID_WD3;
      for (int r = 0; r < NREG; r++) begin
        cnt[r] <= cnt_next[r];
      end
      if (underflow_hit) err_underflow <= 1'b1;
    end
  end

endmodule

// File: tb/tb_id_regfile_scoreboard.sv
// Directed table-driven bench for id_regfile_scoreboard: each record drives one
// cycle of inputs and lists the combinational outputs expected before the edge.
module tb_id_regfile_scoreboard;

  logic        clk;
  logic        rst;
  logic        we3;
  logic [4:0]  a3;
  logic [31:0] wd3;
  logic [4:0]  rs1, rs2, rd, krd;
  logic        u1, u2, issue, rw, kv;
  logic [31:0] rd1, rd2;
  logic        stall, accept, full, err;

  int checks = 0;
  int passes = 0;
  int vecIdx = 0;

  typedef struct {
    logic        we;
    logic [4:0]  a3;
    logic [31:0] wd;
    logic [4:0]  rs1;
    logic        u1;
    logic [4:0]  rs2;
    logic        u2;
    logic        issue;
    logic [4:0]  rd;
    logic        rw;
    logic        kv;
    logic [4:0]  krd;
    logic [31:0] eRd1;
    logic [31:0] eRd2;
    logic        eStall;
    logic        eAccept;
    logic        eFull;
    logic        eErr;
  } vec_t;

  vec_t vecs [30];

  id_regfile_scoreboard dut (
    .clk(clk), .rst(rst),
    .WB_ID_WE3(we3), .WB_ID_RD_A3(a3), .WB_ID_WD3(wd3),
    .id_rs1(rs1), .id_rs2(rs2), .id_rs1_used(u1), .id_rs2_used(u2),
    .id_issue(issue), .id_rd(rd), .id_regwrite(rw),
    .kill_valid(kv), .kill_rd(krd),
    .id_rd1(rd1), .id_rd2(rd2), .id_stall(stall), .id_accept(accept),
    .sb_full(full), .err_underflow(err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("[TB] FAIL %s vec %0d: got %h, expected %h", name, vecIdx, act, exp);
  endtask

  // Drives one record just after an edge, checks mid-cycle, then lets the edge commit it.
  task automatic applyStimulus(input vec_t v);
    we3 = v.we;    a3 = v.a3;   wd3 = v.wd;
    rs1 = v.rs1;   u1 = v.u1;   rs2 = v.rs2; u2 = v.u2;
    issue = v.issue; rd = v.rd; rw = v.rw;
    kv = v.kv;     krd = v.krd;
    #2;
    checkOutput("id_rd1", rd1, v.eRd1);
    checkOutput("id_rd2", rd2, v.eRd2);
    checkOutput("id_stall", {31'd0, stall}, {31'd0, v.eStall});
    checkOutput("id_accept", {31'd0, accept}, {31'd0, v.eAccept});
    checkOutput("sb_full", {31'd0, full}, {31'd0, v.eFull});
    checkOutput("err_underflow", {31'd0, err}, {31'd0, v.eErr});
    @(posedge clk);
    #1;
    vecIdx++;
  endtask

  initial begin
    // Field order: we,a3,wd, rs1,u1, rs2,u2, issue,rd,rw, kv,krd, rd1,rd2,stall,accept,full,err
    vecs[0]  = '{0,0,32'h0,        5,1, 0,1, 1,0,0, 0,0, 32'h0,        32'h0, 0,1,0,0};
    vecs[1]  = '{0,0,32'h0,        0,0, 0,0, 1,5,1, 0,0, 32'h0,        32'h0, 0,1,0,0};
    vecs[2]  = '{1,5,32'hDEADBEEF, 5,1, 0,1, 0,0,0, 0,0, 32'hDEADBEEF, 32'h0, 0,0,0,0};
    vecs[3]  = '{0,0,32'h0,        5,1, 0,0, 0,0,0, 0,0, 32'hDEADBEEF, 32'h0, 0,0,0,0};
    vecs[4]  = '{0,0,32'h0,        0,0, 0,0, 1,7,1, 0,0, 32'h0,        32'h0, 0,1,0,0};
    vecs[5]  = '{0,0,32'h0,        7,1, 0,0, 1,0,0, 0,0, 32'h0,        32'h0, 1,0,0,0};
    vecs[6]  = '{0,0,32'h0,        7,1, 0,0, 1,0,0, 0,0, 32'h0,        32'h0, 1,0,0,0};
    vecs[7]  = '{1,7,32'h12345678, 7,1, 0,0, 1,0,0, 0,0, 32'h12345678, 32'h0, 0,1,0,0};
    vecs[8]  = '{0,0,32'h0,        0,0, 0,0, 1,7,1, 0,0, 32'h0,        32'h0, 0,1,0,0};
    vecs[9]  = '{1,7,32'hA5A5A5A5, 0,0, 0,0, 1,7,1, 0,0, 32'h0,        32'h0, 0,1,0,0};
    vecs[10] = '{0,0,32'h0,        7,1, 0,0, 0,0,0, 0,0, 32'hA5A5A5A5, 32'h0, 1,0,0,0};
    vecs[11] = '{1,7,32'h0BADF00D, 7,1, 0,0, 0,0,0, 0,0, 32'h0BADF00D, 32'h0, 0,0,0,0};
    vecs[12] = '{0,0,32'h0,        7,1, 0,0, 0,0,0, 0,0, 32'h0BADF00D, 32'h0, 0,0,0,0};
    for (int i = 13; i < 20; i++)
      vecs[i] = '{0,0,32'h0,       0,0, 0,0, 1,3,1, 0,0, 32'h0,        32'h0, 0,1,0,0};
    vecs[20] = '{0,0,32'h0,        0,0, 0,0, 1,3,1, 0,0, 32'h0,        32'h0, 0,0,1,0};
    vecs[21] = '{0,0,32'h0,        0,0, 0,0, 1,3,1, 1,3, 32'h0,        32'h0, 0,1,0,0};
    vecs[22] = '{0,0,32'h0,        0,0, 0,0, 1,3,1, 0,0, 32'h0,        32'h0, 0,0,1,0};
    vecs[23] = '{0,0,32'h0,        0,0, 3,1, 1,0,0, 0,0, 32'h0,        32'h0, 1,0,0,0};
    vecs[24] = '{0,0,32'h0,        3,0, 3,0, 1,3,0, 0,0, 32'h0,        32'h0, 0,1,0,0};
    vecs[25] = '{1,0,32'hFFFFFFFF, 0,1, 0,1, 0,0,0, 0,0, 32'h0,        32'h0, 0,0,0,0};
    vecs[26] = '{0,0,32'h0,        0,1, 0,1, 0,0,0, 0,0, 32'h0,        32'h0, 0,0,0,0};
    vecs[27] = '{1,9,32'h11111111, 0,0, 9,1, 0,0,0, 0,0, 32'h0,   32'h11111111, 0,0,0,0};
    vecs[28] = '{0,0,32'h0,        0,0, 9,1, 0,0,0, 0,0, 32'h0,   32'h11111111, 0,0,0,1};
    vecs[29] = '{0,0,32'h0,        5,1, 9,0, 1,0,0, 0,0, 32'hDEADBEEF, 32'h11111111, 0,1,0,1};

    rst = 1'b1;
    we3 = 0; a3 = 0; wd3 = 0; rs1 = 0; rs2 = 0; u1 = 0; u2 = 0;
    issue = 0; rd = 0; rw = 0; kv = 0; krd = 0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;

    for (int i = 0; i < 30; i++) applyStimulus(vecs[i]);

    // Mid-operation reset: x3 counter at 7, err set, x5 holds data.
    rst = 1'b1;
    #2;
    rst = 1'b0;
    @(posedge clk);
    #1;
    applyStimulus('{0,0,32'h0,        5,1, 3,1, 1,3,1, 0,0, 32'h0,        32'h0, 0,1,0,0});
    applyStimulus('{0,0,32'h0,        0,0, 0,0, 1,4,1, 0,0, 32'h0,        32'h0, 0,1,0,0});
    applyStimulus('{0,0,32'h0,        0,0, 0,0, 1,4,1, 0,0, 32'h0,        32'h0, 0,1,0,0});
    // Retire and kill of x4 together at count 2: net zero, no underflow.
    applyStimulus('{1,4,32'hCAFEF00D, 4,1, 0,0, 0,0,0, 1,4, 32'hCAFEF00D, 32'h0, 1,0,0,0});
    applyStimulus('{0,0,32'h0,        4,1, 0,0, 0,0,0, 1,4, 32'hCAFEF00D, 32'h0, 0,0,0,0});
    applyStimulus('{0,0,32'h0,        4,1, 3,1, 0,0,0, 0,0, 32'hCAFEF00D, 32'h0, 1,0,0,1});

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
